// File: rtl/mips_seq_pkg.sv
// Shared definitions for the MIPS memory sequencer: opcode values,
// sequencer state encoding and the store-strobe priority helper.
package mips_seq_pkg;

    // Primary opcode field values decoded elsewhere in the core
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDM  = 6'h3F;

    // Sequencer states; the encoding is fixed so other blocks can decode it
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    // Word store wins over byte store when the decoder raises both.
    // Result bit 1 is the word strobe, bit 0 the byte strobe.
    function automatic logic [1:0] resolve_store(input logic word_we,
                                                 input logic byte_we);
        return {word_we, byte_we & ~word_we};
    endfunction

endpackage

// File: rtl/mips_mem_sequencer.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch
// and data access (FETCH -> EXEC -> [MEM] -> FETCH, HALT on exception).
// Optional macro MEM_WAIT_EN adds the mem_ready handshake: FETCH and MEM
// then wait for mem_ready=1; without it every access completes in one cycle.
module mips_mem_sequencer
    import mips_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        mem_read,
    input  logic        word_we,
    input  logic        byte_we,
    input  logic        writeenable,
    input  logic        except,
    input  logic [31:0] mem_rdata,
`ifdef MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    output logic [31:0] inst,
    output logic [31:0] load_data,
    output logic        pc_en,
    output logic        rf_we,
    output logic        halted,
    output logic [31:0] instr_count
);

    seq_state_e  state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        halted_q, halted_d;

    logic        access_done_s;
    logic        mem_op_s;
    logic [1:0]  store_sel_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic        mem_word_we_s;
    logic        mem_byte_we_s;
    logic        pc_en_s;
    logic        rf_we_s;

`ifdef MEM_WAIT_EN
    assign access_done_s = mem_ready;
`else
    assign access_done_s = 1'b1;
`endif

    assign mem_op_s    = mem_read | word_we | byte_we;
    assign store_sel_s = resolve_store(word_we, byte_we);

    // Next-state, latch updates and combinational memory/commit controls
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        load_data_d   = load_data_q;
        halted_d      = halted_q;
        mem_addr_s    = pc;
        mem_wdata_s   = 32'h0000_0000;
        mem_word_we_s = 1'b0;
        mem_byte_we_s = 1'b0;
        pc_en_s       = 1'b0;
        rf_we_s       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_addr_s = pc;
                if (access_done_s) begin
                    inst_d  = mem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                mem_addr_s = data_addr;
                if (except) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if (mem_op_s) begin
                    state_d = ST_MEM;
                end else begin
                    pc_en_s = 1'b1;
                    rf_we_s = writeenable;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_addr_s    = data_addr;
                mem_wdata_s   = data_wdata;
                mem_word_we_s = store_sel_s[1];
                mem_byte_we_s = store_sel_s[0];
                if (access_done_s) begin
                    load_data_d = mem_rdata;
                    pc_en_s     = 1'b1;
                    rf_we_s     = writeenable;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset overrides every commit and store strobe in the same cycle
        if (reset) begin
            pc_en_s       = 1'b0;
            rf_we_s       = 1'b0;
            mem_word_we_s = 1'b0;
            mem_byte_we_s = 1'b0;
        end else begin
            pc_en_s       = pc_en_s;
            rf_we_s       = rf_we_s;
            mem_word_we_s = mem_word_we_s;
            mem_byte_we_s = mem_byte_we_s;
        end

        if (pc_en_s) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State, latched instruction/load data, halt flag and commit counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            inst_q        <= 32'h0000_0000;
            load_data_q   <= 32'h0000_0000;
            instr_count_q <= 32'h0000_0000;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_q        <= inst_d;
            load_data_q   <= load_data_d;
            instr_count_q <= instr_count_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign mem_word_we = mem_word_we_s;
    assign mem_byte_we = mem_byte_we_s;
    assign pc_en       = pc_en_s;
    assign rf_we       = rf_we_s;
    assign inst        = inst_q;
    assign load_data   = load_data_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Self-checking bench for mips_mem_sequencer. Each instruction is modelled
// as a transaction: fetch cycle, execute cycle, optional memory cycle, with
// expected bus values derived from the instruction kind. Build with
// +define+MEM_WAIT_EN to add the mem_ready stall scenario.
module tb_mips_mem_sequencer;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_SB  = 3;
    localparam int K_WB  = 4;
    localparam int K_EXC = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc, data_addr, data_wdata, mem_rdata;
    logic        mem_read, word_we, byte_we, writeenable, except;
`ifdef MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic [31:0] mem_addr, mem_wdata, inst, load_data, instr_count;
    logic        mem_word_we, mem_byte_we, pc_en, rf_we, halted;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_count;
    logic [31:0] m_load;

    mips_mem_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .mem_read    (mem_read),
        .word_we     (word_we),
        .byte_we     (byte_we),
        .writeenable (writeenable),
        .except      (except),
        .mem_rdata   (mem_rdata),
`ifdef MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_word_we (mem_word_we),
        .mem_byte_we (mem_byte_we),
        .inst        (inst),
        .load_data   (load_data),
        .pc_en       (pc_en),
        .rf_we       (rf_we),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic rand_decoder;
        mem_read    = 1'($urandom_range(0, 1));
        word_we     = 1'($urandom_range(0, 1));
        byte_we     = 1'($urandom_range(0, 1));
        writeenable = 1'($urandom_range(0, 1));
        except      = 1'($urandom_range(0, 1));
    endtask

    // idle-side expectations: no commit, no strobe, no write data
    task automatic check_quiet(input string tag);
        check_eq({tag, "_pc_en"}, 32'(pc_en), 32'd0);
        check_eq({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check_eq({tag, "_wwe"},   32'(mem_word_we), 32'd0);
        check_eq({tag, "_bwe"},   32'(mem_byte_we), 32'd0);
    endtask

    // Reset cycle with store strobes requested; returns #2 into FETCH
    task automatic do_reset;
        reset = 1'b1;
        rand_decoder();
        word_we = 1'b1;
        byte_we = 1'b1;
        #2;
        check_quiet("rst_cycle");
        step();
        reset = 1'b0;
        pc    = $urandom;
        rand_decoder();
        m_count = 32'd0;
        m_load  = 32'd0;
        #1;
        check_eq("rst_inst",   inst, 32'd0);
        check_eq("rst_load",   load_data, 32'd0);
        check_eq("rst_count",  instr_count, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_fetch_addr", mem_addr, pc);
        check_quiet("rst_fetch");
    endtask

    // One instruction from its FETCH cycle to commit (or halt)
    task automatic run_instr(input int kind, input logic wen, input logic [31:0] pc_v,
                             input logic [31:0] da, input logic [31:0] wd,
                             input logic [31:0] iw, input logic [31:0] rw,
                             input logic release_cnt);
        logic is_mem;
        is_mem = (kind >= K_LW) && (kind <= K_WB);
        // FETCH
        pc = pc_v; data_addr = da; data_wdata = wd; mem_rdata = iw;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        rand_decoder();
        #2;
        check_eq("f_addr",  mem_addr, pc_v);
        check_eq("f_wdata", mem_wdata, 32'd0);
        check_quiet("f");
        step();
        // EXEC
        mem_rdata   = ~iw;
        writeenable = wen;
        except      = (kind == K_EXC);
        mem_read    = (kind == K_LW);
        word_we     = (kind == K_SW) || (kind == K_WB);
        byte_we     = (kind == K_SB) || (kind == K_WB);
        #2;
        check_eq("e_inst",  inst, iw);
        check_eq("e_addr",  mem_addr, da);
        check_eq("e_wdata", mem_wdata, 32'd0);
        check_eq("e_wwe",   32'(mem_word_we), 32'd0);
        check_eq("e_bwe",   32'(mem_byte_we), 32'd0);
        check_eq("e_pc_en", 32'(pc_en), 32'(kind == K_ALU));
        check_eq("e_rf_we", 32'(rf_we), 32'((kind == K_ALU) && wen));
        check_eq("e_count", instr_count, m_count);
        if (release_cnt) release dut.instr_count_q;
        step();
        if (kind == K_ALU) m_count = m_count + 32'd1;
        if (kind == K_EXC) begin
            for (int i = 0; i < 10; i++) begin
                rand_decoder();
                mem_rdata = $urandom;
                #2;
                check_eq("h_halted", 32'(halted), 32'd1);
                check_quiet("h");
                check_eq("h_count", instr_count, m_count);
                step();
            end
        end else begin
            if (is_mem) begin
                // MEM
                mem_rdata = rw;
                #2;
                check_eq("m_inst",  inst, iw);
                check_eq("m_addr",  mem_addr, da);
                check_eq("m_wdata", mem_wdata, wd);
                check_eq("m_wwe",   32'(mem_word_we), 32'((kind == K_SW) || (kind == K_WB)));
                check_eq("m_bwe",   32'(mem_byte_we), 32'(kind == K_SB));
                check_eq("m_pc_en", 32'(pc_en), 32'd1);
                check_eq("m_rf_we", 32'(rf_we), 32'(wen));
                step();
                m_count = m_count + 32'd1;
                m_load  = rw;
            end
            check_eq("c_count",  instr_count, m_count);
            check_eq("c_load",   load_data, m_load);
            check_eq("c_halted", 32'(halted), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; pc = 32'd0; data_addr = 32'd0; data_wdata = 32'd0;
        mem_rdata = 32'd0; mem_read = 1'b0; word_we = 1'b0; byte_we = 1'b0;
        writeenable = 1'b0; except = 1'b0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        m_count = 32'd0; m_load = 32'd0;
        step(); step();
        do_reset();

        // add at 0x00400000
        run_instr(K_ALU, 1'b1, 32'h0040_0000, 32'h0000_1234, 32'h5555_aaaa,
                  32'h0109_5020, 32'h0, 1'b0);
        check_eq("add_count", instr_count, 32'd1);
        // sw to 0x10010004
        run_instr(K_SW, 1'b0, 32'h0040_0004, 32'h1001_0004, 32'hDEAD_BEEF,
                  32'hAD09_0004, 32'h0BAD_F00D, 1'b0);
        // lw returning 0x12345678
        run_instr(K_LW, 1'b1, 32'h0040_0008, 32'h1001_0008, 32'h0,
                  32'h8D0A_0008, 32'h1234_5678, 1'b0);
        check_eq("lw_load", load_data, 32'h1234_5678);
        // word and byte store requested together
        run_instr(K_WB, 1'b0, 32'h0040_000C, 32'h1001_0010, 32'hCAFE_0001,
                  32'hA109_0010, 32'h0, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            run_instr($urandom_range(K_ALU, K_WB), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
        end

        // counter wrap from a forced 0xFFFFFFFF
        force dut.instr_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        run_instr(K_ALU, 1'b1, 32'h0040_0100, 32'h0, 32'h0, 32'h0000_0020, 32'h0, 1'b1);
        check_eq("wrap_count", instr_count, 32'h0000_0000);

        // reset while a store sits in MEM
        pc = 32'h0040_0200; mem_rdata = 32'hAC00_0000; rand_decoder();
        step();
        except = 1'b0; mem_read = 1'b0; word_we = 1'b1; byte_we = 1'b0;
        data_addr = 32'h1001_0020; data_wdata = 32'h1111_2222;
        step();
        do_reset();
        run_instr(K_SB, 1'b0, 32'h0040_0204, 32'h1001_0021, 32'h0000_00AB,
                  32'hA000_0001, 32'h7777_0000, 1'b0);

`ifdef MEM_WAIT_EN
        // sb with mem_ready low for three cycles in MEM
        pc = 32'h0040_0300; data_addr = 32'h1001_0031; data_wdata = 32'h0000_00CD;
        mem_rdata = 32'hA000_0031; mem_ready = 1'b1; rand_decoder();
        step();
        except = 1'b0; mem_read = 1'b0; word_we = 1'b0; byte_we = 1'b1; writeenable = 1'b0;
        step();
        mem_rdata = 32'h4242_4242;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #2;
            check_eq("w_bwe",   32'(mem_byte_we), 32'd1);
            check_eq("w_wwe",   32'(mem_word_we), 32'd0);
            check_eq("w_addr",  mem_addr, 32'h1001_0031);
            check_eq("w_pc_en", 32'(pc_en), 32'(i == 3));
            check_eq("w_count", instr_count, m_count);
            step();
        end
        m_count = m_count + 32'd1;
        m_load  = 32'h4242_4242;
        check_eq("w_count_after", instr_count, m_count);
        check_eq("w_load", load_data, m_load);
`endif

        // exception halts until reset
        run_instr(K_EXC, 1'b1, 32'h0040_0400, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_reset();
        run_instr(K_ALU, 1'b1, 32'h0040_0000, 32'h0, 32'h0, 32'h0000_0020, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_sequencer.md
MIPS_MEM_SEQUENCER -- requirements
Module: mips_mem_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock input, reset input, both 1 bit.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  current fetch address
- data_addr  in  32  ALU-computed data address
- data_wdata  in  32  store data (rt value)
- mem_read  in  1  decoder: instruction reads memory (lw/lbu/addm)
- word_we  in  1  decoder: word store
- byte_we  in  1  decoder: byte store
- writeenable  in  1  decoder: instruction writes register file
- except  in  1  decoder: unrecognised instruction
- mem_rdata  in  32  shared memory read data
- mem_ready  in  1  memory access complete (present only with MEM_WAIT_EN)
- mem_addr  out  32  shared memory address
- mem_wdata  out  32  shared memory write data
- mem_word_we  out  1  word write strobe to memory
- mem_byte_we  out  1  byte write strobe to memory
- inst  out  32  latched instruction word
- load_data  out  32  latched data read
- pc_en  out  1  commit pulse: advance PC
- rf_we  out  1  gated register-file write enable
- halted  out  1  sequencer stopped on exception
- instr_count  out  32  committed-instruction counter

Function
REQ-003 SHALL arbitrate the single memory port between instruction fetch and data access with a four-state FSM: FETCH, EXEC, MEM, HALT.
REQ-004 FETCH: mem_addr=pc, strobes 0; on access completion, inst<=mem_rdata and next state EXEC.
REQ-005 EXEC: mem_addr=data_addr; if except=1, next state HALT, no commit; else if mem_read|word_we|byte_we, next state MEM; else pc_en=1, rf_we=writeenable, next state FETCH.
REQ-006 MEM: mem_addr=data_addr, mem_wdata=data_wdata, mem_word_we=word_we, mem_byte_we=byte_we; on completion, load_data<=mem_rdata, pc_en=1, rf_we=writeenable, next state FETCH.
REQ-007 HALT: SHALL stay in HALT until reset; halted=1; pc_en, rf_we and strobes 0.
REQ-008 pc_en and rf_we SHALL be combinational, asserted for exactly one cycle per committed instruction, and never outside EXEC/MEM.
REQ-009 Store strobes SHALL assert only in MEM and never in FETCH or EXEC; if word_we and byte_we are both 1, only mem_word_we SHALL assert.
REQ-010 mem_wdata SHALL be 0 outside MEM.
REQ-011 instr_count SHALL increment by 1 on every cycle with pc_en=1 and wrap from 0xFFFFFFFF to 0.
REQ-012 Latency without MEM_WAIT_EN SHALL be 2 cycles for non-memory instructions and 3 cycles for memory instructions.
REQ-013 inst SHALL hold its value from FETCH completion through the commit cycle; load_data SHALL hold its value until the next MEM completion.

Reset
REQ-014 Reset SHALL take priority over all other inputs, including mid-MEM; a store strobe in a reset cycle SHALL be 0.
REQ-015 After reset, state SHALL be FETCH, and inst, load_data, instr_count and halted SHALL be 0.
REQ-016 In a reset cycle, pc_en, rf_we, mem_word_we and mem_byte_we SHALL be 0.

Configuration
REQ-017 Macro MEM_WAIT_EN SHALL select the memory-timing mode.
- Defined: mem_ready port present. FETCH and MEM SHALL hold all outputs until mem_ready=1, and store strobes SHALL stay asserted while waiting. Every access completes in the cycle mem_ready=1.
- Undefined: mem_ready port absent. Every access completes in one cycle.

Structure
REQ-018 State encoding (FETCH=2'd0, EXEC=2'd1, MEM=2'd2, HALT=2'd3) SHALL be defined in shared package mips_seq_pkg, alongside the existing opcode defines.
REQ-019 SHALL be a single module; the counter and FSM SHALL stay inline, with no sub-module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- add (writeenable=1, no mem) at pc=0x00400000 -> mem_addr=0x00400000 in cycle 0; pc_en=1 and rf_we=1 in cycle 1; instr_count=1.
- sw with data_addr=0x10010004, data_wdata=0xDEADBEEF -> mem_word_we=1 only in cycle 2 with those values; rf_we=0; pc_en=1 in cycle 2.
- lw with mem_rdata=0x12345678 in MEM -> load_data=0x12345678 after cycle 2; rf_we=1 in cycle 2.
- except=1 in EXEC -> halted=1 from the next cycle; no pc_en for 10 cycles; reset -> FETCH, halted=0.
- MEM_WAIT_EN, sb with mem_ready low for 3 cycles -> mem_byte_we held 4 cycles; single pc_en when mem_ready=1.
- instr_count preloaded to 0xFFFFFFFF via a forced value, then one commit -> 0x00000000; reset asserted in MEM -> no strobe, state FETCH.
